// File: rtl/mmio_bridge_if.sv
// CPU-side bus of the MMIO bridge: address, write data, direction,
// ready qualifier, read data and the I/O back-pressure flag.
interface mmio_bridge_if;
    logic        rdy_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;

    modport master (
        output rdy_in, cpu_a, cpu_dout, cpu_wr,
        input  cpu_din, io_buffer_full
    );

    modport slave (
        input  rdy_in, cpu_a, cpu_dout, cpu_wr,
        output cpu_din, io_buffer_full
    );
endinterface

// File: rtl/mmio_bridge.sv
// CPU to RAM / UART memory-mapped bridge with a TX FIFO and halt flag.
// Define MMIO_CYCLE_COUNTER_EN to add the readable 32-bit cycle counter.
module mmio_bridge #(
    parameter int TX_DEPTH_BIT = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    mmio_bridge_if.slave cpu,
    output logic [16:0] ram_a,
    output logic [7:0]  ram_dout,
    output logic        ram_we,
    input  logic [7:0]  ram_din,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        prog_stop
);
    localparam int DEPTH = 1 << TX_DEPTH_BIT;
    localparam logic [TX_DEPTH_BIT:0] CNT_FULL = (TX_DEPTH_BIT + 1)'(DEPTH);
    localparam logic [TX_DEPTH_BIT:0] CNT_HIGH = (TX_DEPTH_BIT + 1)'(DEPTH - 2);

    localparam logic [1:0] SRC_ZERO = 2'd0;
    localparam logic [1:0] SRC_RAM  = 2'd1;
    localparam logic [1:0] SRC_RX   = 2'd2;
    localparam logic [1:0] SRC_CNT  = 2'd3;

    logic [17:0] addr;
    logic        req, rd, wr;
    logic        io_sel, a_tx, a_stop, a_cnt;

    assign addr   = cpu.cpu_a[17:0];
    assign req    = cpu.rdy_in & ~rst_in;
    assign wr     = req & cpu.cpu_wr;
    assign rd     = req & ~cpu.cpu_wr;
    assign io_sel = (addr[17:16] == 2'b11);
    assign a_tx   = (addr == 18'h30000);
    assign a_stop = (addr == 18'h30004);
    assign a_cnt  = (addr[17:2] == 16'hC001);

    logic unused_addr;
    assign unused_addr = ^cpu.cpu_a[31:18];

    assign ram_a    = cpu.cpu_a[16:0];
    assign ram_dout = cpu.cpu_dout;
    assign ram_we   = wr & ~io_sel;
    assign rx_pop   = rd & a_tx & rx_valid;

    logic [7:0] cnt_byte;
`ifdef MMIO_CYCLE_COUNTER_EN
    logic [31:0] cycles;

    always_ff @(posedge clk_in) begin
        if (rst_in)
            cycles <= '0;
        else if (cpu.rdy_in)
            cycles <= cycles + 32'd1;
    end

    always_comb begin
        cnt_byte = cycles[7:0];
        unique case (addr[1:0])
            2'd0: cnt_byte = cycles[7:0];
            2'd1: cnt_byte = cycles[15:8];
            2'd2: cnt_byte = cycles[23:16];
            2'd3: cnt_byte = cycles[31:24];
        endcase
    end
`else
    assign cnt_byte = 8'h00;
`endif

    // TX FIFO
    logic [7:0]              mem [DEPTH];
    logic [TX_DEPTH_BIT-1:0] head, tail;
    logic [TX_DEPTH_BIT:0]   count, count_next;
    logic                    push, push_ok, pop;
    logic [7:0]              push_data;
    logic                    buf_full;

    assign push      = wr & ((a_tx & (|cpu.cpu_dout)) | a_stop);
    assign push_data = a_stop ? 8'h00 : cpu.cpu_dout;
    assign tx_valid  = (count != '0) & ~rst_in;
    assign tx_data   = mem[head];
    assign pop       = tx_valid & tx_ready;
    // a pop in the same cycle frees the slot a full-FIFO push needs
    assign push_ok   = push & ((count != CNT_FULL) | pop);

    always_comb begin
        count_next = count;
        unique case ({push_ok, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (push_ok)
            mem[tail] <= push_data;
    end

    // read source, plus the byte captured for RX/counter reads
    logic [1:0] src, src_next;
    logic [7:0] hold, hold_next;

    always_comb begin
        src_next  = SRC_ZERO;
        hold_next = 8'h00;
        if (rd) begin
            if (!io_sel) begin
                src_next = SRC_RAM;
            end else if (a_tx && rx_valid) begin
                src_next  = SRC_RX;
                hold_next = rx_data;
`ifdef MMIO_CYCLE_COUNTER_EN
            end else if (a_cnt) begin
                src_next  = SRC_CNT;
                hold_next = cnt_byte;
`endif
            end
        end
    end

    logic unused_cnt;
    assign unused_cnt = ^{a_cnt, cnt_byte};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            buf_full  <= 1'b0;
            prog_stop <= 1'b0;
            src       <= SRC_ZERO;
            hold      <= 8'h00;
        end else begin
            if (push_ok)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            count    <= count_next;
            buf_full <= (count_next >= CNT_HIGH);
            if (wr && a_stop)
                prog_stop <= 1'b1;
            src  <= src_next;
            hold <= hold_next;
        end
    end

    assign cpu.io_buffer_full = buf_full;

    always_comb begin
        cpu.cpu_din = 8'h00;
        if (!rst_in) begin
            unique case (src)
                SRC_RAM:  cpu.cpu_din = ram_din;
                SRC_RX:   cpu.cpu_din = hold;
                SRC_CNT:  cpu.cpu_din = hold;
                default:  cpu.cpu_din = 8'h00;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_bridge.sv
// Randomised bench for mmio_bridge against a queue-based reference
// model, with directed sequences pinning literal expectations.
module tb_mmio_bridge;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [16:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic        prog_stop;

    mmio_bridge_if bus ();

    mmio_bridge #(.TX_DEPTH_BIT(3)) dut (
        .clk_in    (clk),
        .rst_in    (rst),
        .cpu       (bus),
        .ram_a     (ram_a),
        .ram_dout  (ram_dout),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_pop    (rx_pop),
        .prog_stop (prog_stop)
    );

    // reference model state
    logic [7:0]  q[$];
    int unsigned mcnt;
    bit          mstop;
    int          rkind;
    logic [7:0]  rbyte;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // drive one cycle's inputs, then compare outputs with the model
    task automatic drive(input bit r, input bit rdy, input logic [31:0] a,
                         input logic [7:0] d, input bit w, input bit txr,
                         input bit rxv, input logic [7:0] rxd,
                         input logic [7:0] rdin);
        bit io, a_tx;
        logic [7:0] exp_din;
        rst = r;
        bus.rdy_in = rdy;
        bus.cpu_a = a;
        bus.cpu_dout = d;
        bus.cpu_wr = w;
        tx_ready = txr;
        rx_valid = rxv;
        rx_data = rxd;
        ram_din = rdin;
        #1;
        if (!chk_en) return;
        io = (a[17:16] == 2'b11);
        a_tx = (a[17:0] == 18'h30000);
        exp_din = 8'h00;
        if (!r && rkind == 1) exp_din = rdin;
        if (!r && rkind == 2) exp_din = rbyte;
        chk("ram_a", ram_a, a[16:0]);
        chk("ram_dout", ram_dout, d);
        chk("ram_we", ram_we, w && rdy && !io && !r);
        chk("rx_pop", rx_pop, !w && rdy && a_tx && rxv && !r);
        chk("tx_valid", tx_valid, q.size() != 0 && !r);
        if (q.size() != 0 && !r)
            chk("tx_data", tx_data, q[0]);
        chk("cpu_din", bus.cpu_din, exp_din);
        chk("io_buffer_full", bus.io_buffer_full, q.size() >= DEPTH - 2);
        chk("prog_stop", prog_stop, mstop);
    endtask

    task automatic tick();
        bit pop, io, push;
        logic [17:0] a18;
        logic [7:0] pd;
        @(posedge clk);
        a18 = bus.cpu_a[17:0];
        io = (a18[17:16] == 2'b11);
        if (rst) begin
            q.delete();
            mcnt = 0;
            mstop = 0;
            rkind = 0;
        end else begin
            pop = (q.size() != 0) && tx_ready;
            push = 0;
            pd = 8'h00;
            if (bus.rdy_in && bus.cpu_wr && io) begin
                if (a18 == 18'h30000 && bus.cpu_dout != 8'h00) begin
                    push = 1;
                    pd = bus.cpu_dout;
                end
                if (a18 == 18'h30004) begin
                    push = 1;
                    mstop = 1;
                end
            end
            if (push && q.size() == DEPTH && !pop) push = 0;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(pd);
            rkind = 0;
            if (bus.rdy_in && !bus.cpu_wr) begin
                if (!io) begin
                    rkind = 1;
                end else if (a18 == 18'h30000 && rx_valid) begin
                    rkind = 2;
                    rbyte = rx_data;
                end
`ifdef MMIO_CYCLE_COUNTER_EN
                else if (a18[17:2] == 16'hC001) begin
                    rkind = 2;
                    rbyte = 8'(mcnt >> (8 * a18[1:0]));
                end
`endif
            end
            if (bus.rdy_in) mcnt = mcnt + 1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit txr, input logic [7:0] rdin);
        drive(0, 1, 32'h0003_0008, 8'h00, 0, txr, 0, 8'h00, rdin);
    endtask

    task automatic wr_io(input logic [31:0] a, input logic [7:0] d,
                         input bit txr);
        drive(0, 1, a, d, 1, txr, 0, 8'h00, 8'h00);
        tick();
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  d;
        rkind = 0;
        mcnt = 0;
        mstop = 0;
        rbyte = 8'h00;
        // reset
        drive(1, 0, 32'h0, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        tick();
        chk_en = 1;
        drive(1, 0, 32'h0, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        tick();
        idle(0, 8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_cpu_din", bus.cpu_din, 8'h00);
        chk("rst_prog_stop", prog_stop, 1'b0);
        chk("rst_buf_full", bus.io_buffer_full, 1'b0);
        tick();

        // single byte with ready high
        wr_io(32'h0003_0000, 8'h41, 1);
        idle(1, 8'h00);
        chk("tx41_valid", tx_valid, 1'b1);
        chk("tx41_data", tx_data, 8'h41);
        tick();
        idle(1, 8'h00);
        chk("tx41_popped", tx_valid, 1'b0);
        tick();

        // zero write ignored, stop write emits 0x00
        wr_io(32'h0003_0000, 8'h00, 0);
        idle(0, 8'h00);
        chk("zero_no_push", tx_valid, 1'b0);
        tick();
        wr_io(32'h0003_0004, 8'h77, 0);
        idle(0, 8'h00);
        chk("stop_flag", prog_stop, 1'b1);
        chk("stop_valid", tx_valid, 1'b1);
        chk("stop_data", tx_data, 8'h00);
        tick();
        idle(1, 8'h00);
        tick();

        // fill, drop, push+pop at full, ordered drain
        for (int i = 0; i < 5; i++) wr_io(32'h0003_0000, 8'(8'h10 + i), 0);
        idle(0, 8'h00);
        chk("full_after5", bus.io_buffer_full, 1'b0);
        tick();
        wr_io(32'h0003_0000, 8'h15, 0);
        idle(0, 8'h00);
        chk("full_after6", bus.io_buffer_full, 1'b1);
        tick();
        for (int i = 6; i < 9; i++) wr_io(32'h0003_0000, 8'(8'h10 + i), 0);
        wr_io(32'h0003_0000, 8'h99, 1);
        for (int i = 0; i < 8; i++) begin
            idle(1, 8'h00);
            chk("drain_order", tx_data, (i == 7) ? 8'h99 : 8'(8'h11 + i));
            tick();
        end
        idle(0, 8'h00);
        chk("drain_empty", tx_valid, 1'b0);
        tick();

        // RAM write then read
        drive(0, 1, 32'h0000_0100, 8'h5A, 1, 0, 0, 8'h00, 8'h00);
        chk("ram_we_lit", ram_we, 1'b1);
        chk("ram_a_lit", ram_a, 17'h00100);
        tick();
        drive(0, 1, 32'h0000_0100, 8'h00, 0, 0, 0, 8'h00, 8'hEE);
        chk("ram_rd_we", ram_we, 1'b0);
        tick();
        idle(0, 8'h5A);
        chk("ram_rd_data", bus.cpu_din, 8'h5A);
        tick();

        // counter byte reads
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 32'h0003_0004 + i, 8'h00, 0, 0, 0, 8'h00, 8'h00);
`ifndef MMIO_CYCLE_COUNTER_EN
            if (i > 0) chk("cnt_off", bus.cpu_din, 8'h00);
`endif
            tick();
        end
        idle(0, 8'h00);
        tick();

        // RX read with and without data
        drive(0, 1, 32'h0003_0000, 8'h00, 0, 0, 1, 8'hC3, 8'h00);
        chk("rx_pop_lit", rx_pop, 1'b1);
        tick();
        drive(0, 1, 32'h0003_0000, 8'h00, 0, 0, 0, 8'h11, 8'h00);
        chk("rx_data_lit", bus.cpu_din, 8'hC3);
        chk("rx_nopop", rx_pop, 1'b0);
        tick();
        idle(0, 8'h00);
        chk("rx_empty_lit", bus.cpu_din, 8'h00);
        tick();

        // reset in the middle of a drain
        for (int i = 0; i < 4; i++) wr_io(32'h0003_0000, 8'(8'h20 + i), 0);
        idle(1, 8'h00);
        tick();
        drive(1, 1, 32'h0003_0000, 8'h55, 1, 1, 0, 8'h00, 8'h00);
        chk("rst_mid_valid", tx_valid, 1'b0);
        tick();
        idle(1, 8'h00);
        chk("rst_after_valid", tx_valid, 1'b0);
        chk("rst_after_full", bus.io_buffer_full, 1'b0);
        tick();

        // randomised traffic
        for (int n = 0; n < 4000; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: a = 32'h0003_0000;
                3:       a = 32'h0003_0004;
                4:       a = 32'h0003_0004 + $urandom_range(1, 3);
                5:       a = 32'h0003_0000 | $urandom_range(8, 16'hFFFF);
                default: begin
                    a = $urandom;
                    if (a[17:16] == 2'b11) a[17] = 1'b0;
                end
            endcase
            d = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 4) != 0,
                  a, d, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                  8'($urandom), 8'($urandom));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmio_bridge.md
MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 Parameter TX_DEPTH_BIT, default 3, SHALL set the UART transmit FIFO depth to 2**TX_DEPTH_BIT entries.
REQ-002 clk_in  input  1  system clock; one clock; all state SHALL change on its rising edge only.
REQ-003 rst_in  input  1  reset, synchronous and active-high.
REQ-004 rdy_in  input  1  when low, CPU-side requests SHALL be ignored and the cycle counter SHALL freeze.
REQ-005 cpu_a  input  32  CPU address bus; only bits 17:0 are decoded.
REQ-006 cpu_dout  input  8  CPU write data.
REQ-007 cpu_wr  input  1  1 = write, 0 = read.
REQ-008 cpu_din  output  8  read data returned to the CPU.
REQ-009 io_buffer_full  output  1  tells the CPU to hold I/O writes.
REQ-010 ram_a  output  17  RAM address.
REQ-011 ram_dout  output  8  RAM write data.
REQ-012 ram_we  output  1  RAM write enable.
REQ-013 ram_din  input  8  RAM read data, valid 1 cycle after the address.
REQ-014 tx_data  output  8  UART transmit byte.
REQ-015 tx_valid  output  1  tx_data is valid.
REQ-016 tx_ready  input  1  UART accepts the byte.
REQ-017 rx_data  input  8  UART receive byte.
REQ-018 rx_valid  input  1  rx_data holds an unread byte.
REQ-019 rx_pop  output  1  single-cycle pulse that consumes rx_data.
REQ-020 prog_stop  output  1  sticky flag: the program has stopped.

Function
REQ-021 Address decode: cpu_a[17:16]==2'b11 SHALL select I/O space; all other addresses SHALL select RAM.
REQ-022 RAM path SHALL be combinational: ram_a=cpu_a[16:0] and ram_dout=cpu_dout; ram_we=cpu_wr & rdy_in & RAM-select.
REQ-023 Read latency SHALL be exactly 1 cycle. A registered source select (RAM, RX, CNT, ZERO) captured at the request cycle SHALL drive the cpu_din mux in the next cycle.
REQ-024 Write to 0x30000 with a nonzero byte SHALL push that byte into the TX FIFO. A 0x00 write SHALL be ignored.
REQ-025 Write to 0x30004 SHALL set prog_stop and push 0x00 into the TX FIFO.
REQ-026 Read of 0x30000 SHALL return rx_data next cycle and pulse rx_pop in the request cycle if rx_valid=1; otherwise it SHALL return 0x00 with no pop.
REQ-027 Read of 0x30004-0x30007 SHALL return the byte of the 32-bit cycle counter selected by cpu_a[1:0] (0 = LSB). The counter value SHALL be sampled in the request cycle.
REQ-028 Any other I/O address SHALL read 0x00 and SHALL ignore writes.
REQ-029 Cycle counter: 32 bits, +1 every cycle with rdy_in=1, wraps 0xFFFFFFFF->0.
REQ-030 TX FIFO: circular head and tail pointers plus a count of TX_DEPTH_BIT+1 bits; pointers wrap modulo the depth.
REQ-031 tx_valid SHALL equal (count!=0), and tx_data SHALL equal the head entry. A pop SHALL occur on tx_valid & tx_ready, independent of rdy_in.
REQ-032 Simultaneous push and pop SHALL leave count unchanged. At count=full, a push with a simultaneous pop SHALL succeed.
REQ-033 A push at full with no pop SHALL be dropped and FIFO state SHALL be unchanged.
REQ-034 io_buffer_full SHALL be registered and equal 1 when count >= depth-2, giving one in-flight write of slack.
REQ-035 Empty FIFO: tx_valid=0, and a tx_ready pulse SHALL have no effect.

Reset
REQ-036 On rst_in=1 at a clock edge, the block SHALL clear: FIFO pointers and count, cycle counter, prog_stop, io_buffer_full, and the read source select (to ZERO).
REQ-037 During and after reset: cpu_din=0x00, tx_valid=0, rx_pop=0, ram_we=0. A mid-drain reset SHALL discard all queued bytes.

Configuration
REQ-038 Macro MMIO_CYCLE_COUNTER_EN: when defined, the 32-bit cycle counter SHALL be implemented per REQ-027 and REQ-029.
REQ-039 When MMIO_CYCLE_COUNTER_EN is undefined, no counter register SHALL exist, reads of 0x30004-0x30007 SHALL return 0x00, and the write-0x30004 behaviour SHALL be unchanged.

Verification
REQ-040 Write 0x41 to 0x30000 with tx_ready=1 -> tx_valid=1 with tx_data=0x41 next cycle; popped in the same cycle.
REQ-041 Write 0x00 to 0x30000 -> no push and tx_valid stays 0. Then write to 0x30004 -> prog_stop=1 and tx_data=0x00 is emitted.
REQ-042 tx_ready=0, 6 writes with depth 8 -> io_buffer_full=1 after the 6th; 3 further writes -> count=8 and the 9th is dropped; FIFO order intact on drain.
REQ-043 RAM write 0x5A to 0x00100, then read 0x00100 with ram_din=0x5A -> cpu_din=0x5A exactly 1 cycle after the read.
REQ-044 Counter at 0x12345678, reads of 0x30004-0x30007 on consecutive cycles -> bytes 0x78 (sampled at 0x12345678), 0x56, 0x34, 0x12, each byte from the counter value sampled in its own request cycle; with the macro undefined -> all reads 0x00.
REQ-045 Full FIFO plus simultaneous push and pop -> count stays 8. Reset asserted mid-drain -> tx_valid=0 and count=0 on the next cycle.
